stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 8, number of input channels (2..32).
REQ-002 Parameter DW, default 8, data width per channel (1..64).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port in_valid  input  N_CH  per-channel valid.
REQ-006 Port in_data  input  N_CH*DW  channel i occupies bits [i*DW +: DW].
REQ-007 Port in_ready  output  N_CH  per-channel accept, at most one bit set.
REQ-008 Port out_valid  output  1  output register holds a word.
REQ-009 Port out_ready  input  1  downstream accept.
REQ-010 Port out_data  output  DW  registered selected word.
REQ-011 Port out_ch  output  CW  registered source channel index, CW = max(1, clog2(N_CH)).

Function
REQ-012 Single output register stage; input-to-output latency exactly 1 cycle.
REQ-013 Register is loadable when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-014 When loadable and any in_valid set, exactly one channel is granted; in_ready is one-hot on it, combinational from in_valid, pointer and out state.
REQ-015 When not loadable, or no in_valid set, in_ready is all zeros.
REQ-016 Grant = first set in_valid searching upward from ptr, wrapping N_CH-1 -> 0.
REQ-017 On grant g: out_data <= in_data[g], out_ch <= g, out_valid <= 1, ptr <= (g+1) mod N_CH.
REQ-018 Loadable with no in_valid: out_valid <= 0 if drained, else holds; ptr unchanged.
REQ-019 out_valid=1 and out_ready=0: out_data, out_ch, out_valid hold stable.
REQ-020 Drain and load in the same cycle gives back-to-back words with no bubble.
REQ-021 in_valid deasserted without a handshake is not an error; no grant is recorded.
REQ-022 N_CH not a power of two: ptr wraps at N_CH, never indexes past N_CH-1.
REQ-023 Transfer on input side occurs iff in_valid[i] & in_ready[i]; output side iff out_valid & out_ready.

Reset
REQ-024 rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-025 While rst=1, in_ready is all zeros irrespective of inputs.
REQ-026 Reset mid-transfer discards the held word; no word is emitted after rst deasserts until a new grant.

Configuration
REQ-027 Macro STREAM_MUX_RR_FORCE_SEL_EN: when defined, adds ports force_en (input 1) and force_sel (input CW).
REQ-028 With macro and force_en=1: only channel force_sel is eligible; ptr is not updated; force_sel >= N_CH grants nothing.
REQ-029 With macro and force_en=0, or without macro: pure round-robin per REQ-016; no extra ports.

Structure
REQ-030 Shared package stream_mux_pkg holds the clog2-based width function and the reset constants.
REQ-031 Sub-module rr_pick (one-hot round-robin picker: request vector, pointer -> one-hot grant, index, any) is instantiated once.

Verification
REQ-032 Reset: rst=1 for 2 cycles, in_valid=8'hFF -> in_ready=0, out_valid=0, out_ch=0 throughout.
REQ-033 Fairness: in_valid=8'hFF, out_ready=1 constant, 16 cycles -> out_ch sequence 0,1,..,7,0,..,7, one word per cycle.
REQ-034 Skip: in_valid=8'b1000_0100, ptr=0, out_ready=1 -> grants 2, 7, 2, 7; out_data matches in_data slice each time.
REQ-035 Backpressure: word from ch3 (data 8'hA5) held, out_ready=0 for 5 cycles -> out_data=8'hA5, out_ch=3 stable, in_ready=0; out_ready=1 -> next word loads same cycle.
REQ-036 Reset mid-stream: out_valid=1 with out_ready=0, assert rst -> next cycle out_valid=0, ptr=0, first grant after release searches from channel 0.
REQ-037 With STREAM_MUX_RR_FORCE_SEL_EN, N_CH=5: force_en=1, force_sel=4, in_valid=5'h1F -> only ch4 granted, ptr unchanged; force_sel=6 -> no grant.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: the index-width
// helper and the values the output register and pointer take on reset.
package stream_mux_pkg;

  // Index width for n channels; always at least one bit so a 2-channel mux still has an index.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic RST_OUT_VALID = 1'b0;
  localparam int   RST_PTR       = 0;
  localparam int   RST_OUT_CH    = 0;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// One-hot round-robin picker: returns the first set request at or above ptr,
// wrapping from N-1 back to 0, as a one-hot grant plus its binary index.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      // ptr is kept below N, so a single subtraction is enough to wrap.
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH-to-1 round-robin stream multiplexer with a single registered output stage.
// Optional macro STREAM_MUX_RR_FORCE_SEL_EN adds force_en/force_sel to pin the grant to one channel.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 8,
  parameter  int DW   = 8,
  localparam int CW   = clog2w(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
  input  logic               force_en,
  input  logic [CW-1:0]      force_sel,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [CW-1:0]      out_ch
);

  logic [CW-1:0]   ptr;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt;
  logic [CW-1:0]   pick_idx;
  logic            pick_any;
  logic            loadable;
  logic            force_hold;
  logic            load;

  always_comb begin
    req        = in_valid;
    force_hold = 1'b0;
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    // A forced selector outside 0..N_CH-1 matches no channel and so grants nothing.
    if (force_en) begin
      force_hold = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        req[i] = in_valid[i] && (force_sel == CW'(i));
      end
    end
`endif
  end

  rr_pick #(.N(N_CH)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign loadable = !out_valid || out_ready;
  assign load     = loadable && pick_any && !rst;
  assign in_ready = (loadable && !rst) ? gnt : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= RST_OUT_VALID;
      out_data  <= '0;
      out_ch    <= CW'(RST_OUT_CH);
      ptr       <= CW'(RST_PTR);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(pick_idx)*DW +: DW];
      out_ch    <= pick_idx;
      if (!force_hold) begin
        ptr <= (pick_idx == CW'(N_CH - 1)) ? '0 : pick_idx + CW'(1);
      end
    end else if (loadable) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr: an 8-channel instance plus a
// 5-channel instance for pointer wrap and, when the macro is defined, forced selection.
module tb_stream_mux_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_valid;
  logic [63:0]  in_data;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [2:0]   out_ch;

  logic [4:0]   v5;
  logic [39:0]  d5;
  logic [4:0]   ir5;
  logic         ov5;
  logic         or5;
  logic [7:0]   od5;
  logic [2:0]   oc5;
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
  logic         fe8, fe5;
  logic [2:0]   fs8, fs5;
`endif

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    .force_en(fe8), .force_sel(fs8),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  stream_mux_rr #(.N_CH(5), .DW(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_ready(ir5),
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    .force_en(fe5), .force_sel(fs5),
`endif
    .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_ch(oc5)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = '0;
    v5 = '0; d5 = '0; or5 = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      tests_run++; if (in_ready !== 8'h00) begin fails++; $display("FAIL reset_in_ready: got %h want 00", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++; if (out_ch !== 3'd0) begin fails++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    end
    rst = 1'b0; in_valid = '0;
  endtask

  task automatic test_fairness();
    logic [7:0] exp_rdy;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 8'h01) begin fails++; $display("FAIL fair_first_ready: got %h want 01", in_ready); end
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      exp_rdy = 8'(1 << ((k + 1) % 8));
      tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fair_valid[%0d]: got %b want 1", k, out_valid); end
      tests_run++; if (out_ch !== 3'(k % 8)) begin fails++; $display("FAIL fair_ch[%0d]: got %0d want %0d", k, out_ch, k % 8); end
      tests_run++; if (out_data !== 8'(8'h10 + k % 8)) begin fails++; $display("FAIL fair_data[%0d]: got %h want %h", k, out_data, 8'(8'h10 + k % 8)); end
      tests_run++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL fair_ready[%0d]: got %h want %h", k, in_ready, exp_rdy); end
    end
    in_valid = '0;
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fair_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_skip();
    logic [2:0] exp_ch [4] = '{3'd2, 3'd7, 3'd2, 3'd7};
    logic [7:0] exp_d  [4] = '{8'h22, 8'h77, 8'h22, 8'h77};
    in_data[2*8 +: 8] = 8'h22; in_data[7*8 +: 8] = 8'h77;
    in_valid = 8'b1000_0100; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tests_run++; if (out_ch !== exp_ch[k]) begin fails++; $display("FAIL skip_ch[%0d]: got %0d want %0d", k, out_ch, exp_ch[k]); end
      tests_run++; if (out_data !== exp_d[k]) begin fails++; $display("FAIL skip_data[%0d]: got %h want %h", k, out_data, exp_d[k]); end
    end
    in_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    in_data[3*8 +: 8] = 8'hA5; in_data[4*8 +: 8] = 8'h4B;
    in_valid = 8'h08; out_ready = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (out_ch !== 3'd3 || out_data !== 8'hA5) begin fails++; $display("FAIL bp_load: got ch %0d data %h want ch 3 data a5", out_ch, out_data); end
    in_valid = 8'hFF;
    #1;
    tests_run++; if (in_ready !== 8'h00) begin fails++; $display("FAIL bp_ready_held: got %h want 00", in_ready); end
    repeat (5) begin
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd3) begin
        fails++; $display("FAIL bp_hold: got v %b data %h ch %0d want v 1 data a5 ch 3", out_valid, out_data, out_ch);
      end
      tests_run++; if (in_ready !== 8'h00) begin fails++; $display("FAIL bp_hold_ready: got %h want 00", in_ready); end
    end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 8'h10) begin fails++; $display("FAIL bp_release_ready: got %h want 10", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b1 || out_ch !== 3'd4 || out_data !== 8'h4B) begin
      fails++; $display("FAIL bp_next_word: got v %b ch %0d data %h want v 1 ch 4 data 4b", out_valid, out_ch, out_data);
    end
    in_valid = '0;
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    // Pointer sits at 5, so channel 1 is found after wrapping.
    in_data[1*8 +: 8] = 8'hC1; in_data[0*8 +: 8] = 8'h10;
    in_valid = 8'h02; out_ready = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b1 || out_ch !== 3'd1) begin fails++; $display("FAIL mid_load: got v %b ch %0d want v 1 ch 1", out_valid, out_ch); end
    rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 8'h00) begin fails++; $display("FAIL mid_rst_ready: got %h want 00", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0 || out_ch !== 3'd0 || out_data !== 8'h00) begin
      fails++; $display("FAIL mid_rst_state: got v %b ch %0d data %h want 0 0 00", out_valid, out_ch, out_data);
    end
    tests_run++; if (in_ready !== 8'h00) begin fails++; $display("FAIL mid_rst_ready2: got %h want 00", in_ready); end
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 8'h01) begin fails++; $display("FAIL mid_post_ready: got %h want 01", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (out_ch !== 3'd0 || out_data !== 8'h10) begin fails++; $display("FAIL mid_post_grant: got ch %0d data %h want ch 0 data 10", out_ch, out_data); end
    in_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap5();
    logic [2:0] exp_ch [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'(8'h50 + i);
    v5 = 5'h1F; or5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      tests_run++; if (ov5 !== 1'b1 || oc5 !== exp_ch[k]) begin fails++; $display("FAIL wrap5_ch[%0d]: got v %b ch %0d want v 1 ch %0d", k, ov5, oc5, exp_ch[k]); end
      tests_run++; if (od5 !== 8'(8'h50 + exp_ch[k])) begin fails++; $display("FAIL wrap5_data[%0d]: got %h want %h", k, od5, 8'(8'h50 + exp_ch[k])); end
    end
    v5 = '0;
    @(posedge clk); #1;
    tests_run++; if (ov5 !== 1'b0) begin fails++; $display("FAIL wrap5_drain: got %b want 0", ov5); end
  endtask

`ifdef STREAM_MUX_RR_FORCE_SEL_EN
  task automatic test_force();
    // Pointer of the 5-channel instance is 1 after the wrap test.
    fe5 = 1'b1; fs5 = 3'd4; v5 = 5'h1F; or5 = 1'b1;
    #1;
    tests_run++; if (ir5 !== 5'h10) begin fails++; $display("FAIL force_ready: got %h want 10", ir5); end
    @(posedge clk); #1;
    tests_run++; if (ov5 !== 1'b1 || oc5 !== 3'd4) begin fails++; $display("FAIL force_grant: got v %b ch %0d want v 1 ch 4", ov5, oc5); end
    fs5 = 3'd6;
    #1;
    tests_run++; if (ir5 !== 5'h00) begin fails++; $display("FAIL force_oob_ready: got %h want 00", ir5); end
    @(posedge clk); #1;
    tests_run++; if (ov5 !== 1'b0) begin fails++; $display("FAIL force_oob_valid: got %b want 0", ov5); end
    fe5 = 1'b0;
    #1;
    tests_run++; if (ir5 !== 5'h02) begin fails++; $display("FAIL force_ptr_kept: got %h want 02", ir5); end
    @(posedge clk); #1;
    tests_run++; if (oc5 !== 3'd1) begin fails++; $display("FAIL force_rr_resume: got %0d want 1", oc5); end
    v5 = '0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    fe8 = 1'b0; fs8 = '0; fe5 = 1'b0; fs5 = '0;
`endif
    test_reset();
    test_fairness();
    test_skip();
    test_backpressure();
    test_reset_mid();
    test_wrap5();
`ifdef STREAM_MUX_RR_FORCE_SEL_EN
    test_force();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
